// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared width derivation, configuration check and status type for sync_fifo_param
package sync_fifo_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AE_LEVEL = 2;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic bit cfg_ok(input int width, input int depth, input int ae, input int af);
    return width >= 1 && depth >= 4 && (depth & (depth - 1)) == 0 && ae < af && af <= depth;
  endfunction
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x WIDTH flop array, one write port, registered read port cleared by reset
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (!rst_n) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, threshold flags, sticky errors and flush
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  localparam int AW = addr_w(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic             i_err_clr,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [CW-1:0]    o_count,
  output logic             o_overflow,
  output logic             o_underflow
);
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] L_AF = CW'(AF_LEVEL);
  localparam logic [CW-1:0] L_AE = CW'(AE_LEVEL);
  if (!cfg_ok(WIDTH, DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_cfg
    $error("sync_fifo_param: invalid WIDTH/DEPTH/AE_LEVEL/AF_LEVEL");
  end
  logic [CW-1:0] r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt, w_cnt_nxt;
  logic r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_rd_valid;
  logic w_live, w_rd_acc, w_wr_acc;
  always_comb begin
    w_live = rst_n && !i_flush;
    w_rd_acc = w_live && i_rd_en && !r_empty;
    w_wr_acc = w_live && i_wr_en && (!r_full || w_rd_acc);
    w_wr_nxt = w_live ? r_wr_ptr + CW'(w_wr_acc) : '0;
    w_rd_nxt = w_live ? r_rd_ptr + CW'(w_rd_acc) : '0;
    w_cnt_nxt = w_wr_nxt - w_rd_nxt;
  end
  always_ff @(posedge clk) begin
    r_wr_ptr <= w_wr_nxt;
    r_rd_ptr <= w_rd_nxt;
    r_full <= w_cnt_nxt == L_DEPTH;
    r_empty <= w_cnt_nxt == '0;
    r_af <= w_cnt_nxt >= L_AF;
    r_ae <= w_cnt_nxt <= L_AE;
    r_rd_valid <= w_rd_acc;
    r_ovf <= rst_n && ((w_live && i_wr_en && !w_wr_acc) || (r_ovf && !i_err_clr));
    r_udf <= rst_n && ((w_live && i_rd_en && !w_rd_acc) || (r_udf && !i_err_clr));
  end
  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (i_wr_data),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (o_rd_data)
  );
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_rd_valid = r_rd_valid;
  assign o_full = r_full;
  assign o_empty = r_empty;
  assign o_almost_full = r_af;
  assign o_almost_empty = r_ae;
  assign o_overflow = r_ovf;
  assign o_underflow = r_udf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed plus randomized checking of sync_fifo_param against a queue model
module tb_sync_fifo_param;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_flush = 1'b0, i_wr_en = 1'b0, i_rd_en = 1'b0, i_err_clr = 1'b0;
  logic [WIDTH-1:0] i_wr_data = '0;
  logic [WIDTH-1:0] o_rd_data;
  logic o_rd_valid, o_full, o_empty, o_almost_full, o_almost_empty, o_overflow, o_underflow;
  logic [4:0] o_count;
  int total = 0, pass = 0, fails = 0;
  logic [WIDTH-1:0] q[$];
  logic m_ovf = 1'b0, m_udf = 1'b0, m_rv = 1'b0;
  logic [WIDTH-1:0] m_rd = '0;
  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_flush        (i_flush),
    .i_wr_en        (i_wr_en),
    .i_wr_data      (i_wr_data),
    .i_rd_en        (i_rd_en),
    .i_err_clr      (i_err_clr),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic rn, input logic wr, input logic [WIDTH-1:0] wd, input logic rd, input logic fl, input logic ec);
    int n;
    logic racc, wacc;
    n = q.size();
    if (!rn) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0;
    end else if (fl) begin
      q.delete();
      m_rv = 0;
      if (ec) begin m_ovf = 0; m_udf = 0; end
    end else begin
      racc = rd && n > 0;
      wacc = wr && (n < DEPTH || racc);
      m_rv = racc;
      if (racc) m_rd = q.pop_front();
      if (wacc) q.push_back(wd);
      m_ovf = (wr && !wacc) ? 1'b1 : ec ? 1'b0 : m_ovf;
      m_udf = (rd && !racc) ? 1'b1 : ec ? 1'b0 : m_udf;
    end
  endtask
  task automatic step(input logic rn, input logic wr, input logic [WIDTH-1:0] wd, input logic rd, input logic fl, input logic ec);
    int n;
    rst_n = rn; i_wr_en = wr; i_wr_data = wd; i_rd_en = rd; i_flush = fl; i_err_clr = ec;
    @(posedge clk);
    model(rn, wr, wd, rd, fl, ec);
    #1;
    n = q.size();
    chk("count", 32'(o_count), n);
    chk("full", 32'(o_full), 32'(n == DEPTH));
    chk("empty", 32'(o_empty), 32'(n == 0));
    chk("almost_full", 32'(o_almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(o_almost_empty), 32'(n <= AE));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("underflow", 32'(o_underflow), 32'(m_udf));
    chk("rd_valid", 32'(o_rd_valid), 32'(m_rv));
    chk("rd_data", o_rd_data, m_rd);
  endtask
  initial begin
    #2;
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h1, 1, 1, 1);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_empty", 32'(o_empty), 1);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 32'(i), 0, 0, 0);
      chk("fill_af", 32'(o_almost_full), 32'(i >= 13));
    end
    chk("plan_full", 32'(o_full), 1);
    chk("plan_count16", 32'(o_count), 16);
    step(1, 1, 32'hDEAD, 0, 0, 0);
    chk("plan_ovf", 32'(o_overflow), 1);
    step(1, 0, 0, 0, 0, 0);
    chk("plan_ovf_sticky", 32'(o_overflow), 1);
    step(1, 0, 0, 0, 0, 1);
    chk("plan_ovf_clr", 32'(o_overflow), 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 1, 0, 0);
      chk("drain_data", o_rd_data, 32'(i));
    end
    chk("plan_empty", 32'(o_empty), 1);
    step(1, 0, 0, 1, 0, 0);
    chk("plan_udf", 32'(o_underflow), 1);
    chk("plan_udf_rv", 32'(o_rd_valid), 0);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 1, 32'h100 + 32'(i), 0, 0, 0);
    step(1, 1, 32'hBEEF, 1, 0, 0);
    chk("wrap_rd", o_rd_data, 32'h100);
    chk("wrap_count", 32'(o_count), 16);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 0, 0);
    chk("wrap_last", o_rd_data, 32'hBEEF);
    step(1, 1, 32'h55, 1, 0, 0);
    chk("empty_rw_count", 32'(o_count), 1);
    chk("empty_rw_udf", 32'(o_underflow), 1);
    step(1, 0, 0, 1, 0, 1);
    chk("empty_rw_data", o_rd_data, 32'h55);
    for (int i = 0; i < 5; i++) step(1, 1, 32'h200 + 32'(i), 0, 0, 0);
    step(1, 1, 32'h999, 1, 1, 0);
    chk("flush_count", 32'(o_count), 0);
    chk("flush_ovf", 32'(o_overflow), 0);
    step(1, 1, 32'h300, 0, 0, 0);
    step(1, 1, 32'h301, 0, 0, 0);
    step(0, 1, 32'h302, 1, 0, 0);
    chk("midrst_rv", 32'(o_rd_valid), 0);
    chk("midrst_data", o_rd_data, 0);
    for (int c = 0; c < 800; c++) begin
      int pw, pr;
      logic fl;
      pw = ((c / 100) % 2 == 0) ? 75 : 30;
      pr = 100 - pw;
      fl = $urandom_range(0, 59) == 0;
      step($urandom_range(0, 199) != 0, $urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < pr,
           fl, !fl && $urandom_range(0, 19) == 0);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
